// File: rtl/drive_arbiter_if.sv
// Signal bundle between the command sources and the drive arbiter.
// cmd_valid is a one-cycle pulse with no ready: the arbiter samples arduino_command on every pulse and never stalls the link.
interface drive_arbiter_if;
  logic       cmd_valid;
  logic [7:0] arduino_command;
  logic       manual_on;
  logic [3:0] auto_command;
  logic [3:0] drive_cmd;
  logic       mode;
  logic       timeout;
  logic [1:0] fsm_state;

  modport master (
    output cmd_valid, arduino_command, manual_on, auto_command,
    input  drive_cmd, mode, timeout, fsm_state
  );

  modport slave (
    input  cmd_valid, arduino_command, manual_on, auto_command,
    output drive_cmd, mode, timeout, fsm_state
  );
endinterface

// File: rtl/drive_arbiter.sv
// Chooses between manual (Arduino) and autonomous motor commands, with a debounce filter,
// a forced-stop dwell on mode change or direction reversal, and a manual-link watchdog.
module drive_arbiter #(
  parameter int STABLE_COUNT   = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int DWELL_CYCLES   = 1000
) (
  input  logic            clk,
  input  logic            reset,
  drive_arbiter_if.slave  arb
);

  localparam int SC_W = $clog2(STABLE_COUNT + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STABLE_COUNT);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DWELL   = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e          state_q;
  logic [3:0]      drive_q;
  logic            mode_q;
  logic            timeout_q;
  logic [3:0]      cand_q, cand_d;
  logic [SC_W-1:0] cnt_q, cnt_d;
  logic [3:0]      man_tgt_q, man_tgt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [DW_W-1:0] dwell_q;

  logic [3:0] man_dec, auto_dec, target;
  logic       mode_chg, wd_expired, reversal;

  // Unlisted bytes decode to stop so a corrupted link byte can never move the robot.
  function automatic logic [3:0] decode(input logic [7:0] b);
    case (b)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
      8'h05, 8'h08, 8'h09, 8'h0C: decode = b[3:0];
      8'h0A:                      decode = 4'h1;
      default:                    decode = 4'h0;
    endcase
  endfunction

  always_comb begin
    man_dec    = decode(arb.arduino_command);
    auto_dec   = decode({4'h0, arb.auto_command});
    target     = mode_q ? man_tgt_q : auto_dec;
    mode_chg   = (arb.manual_on != mode_q);
    wd_expired = mode_q && (wd_q == WD_MAX) &&
                 ((state_q == ST_RUN) || (state_q == ST_DWELL));
    reversal   = (target[0] & drive_q[2]) | (target[2] & drive_q[0]);

    if (!mode_q || arb.cmd_valid) wd_d = '0;
    else if (wd_q != WD_MAX)      wd_d = wd_q + WD_W'(1);
    else                          wd_d = wd_q;

    cand_d    = cand_q;
    cnt_d     = cnt_q;
    man_tgt_d = man_tgt_q;
    if (mode_chg) begin
      cand_d    = '0;
      cnt_d     = '0;
      man_tgt_d = '0;
    end else begin
      if (arb.cmd_valid) begin
        if (man_dec == cand_q) begin
          if (cnt_q != SC_MAX) cnt_d = cnt_q + SC_W'(1);
        end else begin
          cand_d = man_dec;
          cnt_d  = SC_W'(1);
        end
        if (cnt_d == SC_MAX) man_tgt_d = cand_d;
      end
      if (wd_expired) man_tgt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drive_q   <= '0;
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      man_tgt_q <= '0;
      wd_q      <= '0;
      dwell_q   <= '0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      man_tgt_q <= man_tgt_d;
      wd_q      <= wd_d;
      if (mode_chg) begin
        state_q   <= ST_DWELL;
        mode_q    <= arb.manual_on;
        drive_q   <= '0;
        timeout_q <= 1'b0;
        dwell_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_RUN;
            drive_q <= '0;
          end
          ST_RUN: begin
            if (wd_expired) begin
              state_q   <= ST_TIMEOUT;
              drive_q   <= '0;
              timeout_q <= 1'b1;
            end else if (reversal) begin
              state_q <= ST_DWELL;
              drive_q <= '0;
              dwell_q <= '0;
            end else begin
              drive_q <= target;
            end
          end
          ST_DWELL: begin
            // Target changes here are ignored until exit, where the latest one is applied.
            if (wd_expired) begin
              state_q   <= ST_TIMEOUT;
              timeout_q <= 1'b1;
            end else if (dwell_q == DW_LAST) begin
              state_q <= ST_RUN;
              drive_q <= target;
            end else begin
              dwell_q <= dwell_q + DW_W'(1);
            end
          end
          ST_TIMEOUT: begin
            if (arb.cmd_valid) begin
              state_q   <= ST_IDLE;
              timeout_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign arb.drive_cmd = drive_q;
  assign arb.mode      = mode_q;
  assign arb.timeout   = timeout_q;
  assign arb.fsm_state = state_q;

endmodule

// File: doc/drive_arbiter.md
DRIVE_ARBITER -- requirements
Module: drive_arbiter

Interface
REQ-001 Parameter STABLE_COUNT, default 2: consecutive identical manual bytes required before a manual command is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000: manual-link watchdog limit, in clk cycles.
REQ-003 Parameter DWELL_CYCLES, default 1000: forced-stop duration on mode change or direction reversal.
REQ-004 Port clk  in  1  system clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port cmd_valid  in  1  one-cycle pulse marking a new arduino_command byte.
REQ-007 Port arduino_command  in  8  manual command byte from the Arduino link.
REQ-008 Port manual_on  in  1  1 = manual source selected, 0 = autonomous source selected.
REQ-009 Port auto_command  in  4  autonomous command from the decision tree: bit0 fwd, bit1 left, bit2 back, bit3 right.
REQ-010 Port drive_cmd  out  4  registered motor command, same bit encoding as auto_command.
REQ-011 Port mode  out  1  registered copy of the source currently in force (1 = manual).
REQ-012 Port timeout  out  1  high while the arbiter is in TIMEOUT.
REQ-013 Port fsm_state  out  2  IDLE=0, RUN=1, DWELL=2, TIMEOUT=3.

Function
REQ-014 Legal codes are 0x00, 0x01, 0x02, 0x03, 0x04, 0x05, 0x08, 0x09 and 0x0C; 0x0A SHALL decode to 0x1; any other byte, including one with a nonzero upper nibble, SHALL decode to 0x0 (stop).
REQ-015 auto_command SHALL be decoded by the same table, zero-extended to 8 bits.
REQ-016 The manual filter SHALL hold a candidate code and a count: on cmd_valid, a decoded byte equal to the candidate increments the count (saturating at STABLE_COUNT); a different byte loads the candidate and sets the count to 1.
REQ-017 The manual target SHALL update to the candidate when the count reaches STABLE_COUNT; otherwise the previous manual target is held.
REQ-018 The target SHALL be the manual target when mode=1 and the decoded auto_command when mode=0.
REQ-019 The states SHALL be IDLE (drive_cmd=0), RUN (drive_cmd follows target), DWELL (drive_cmd=0, dwell counter running) and TIMEOUT (drive_cmd=0, timeout=1).
REQ-020 IDLE->RUN SHALL occur the cycle after reset deasserts.
REQ-021 In RUN, drive_cmd SHALL equal the target one cycle after the target changes.
REQ-022 Reversal: RUN->DWELL SHALL occur when the target has the fwd bit while drive_cmd has the back bit, or vice versa; drive_cmd=0 for DWELL_CYCLES cycles, then DWELL->RUN.
REQ-023 Mode change: when manual_on differs from mode, the arbiter SHALL enter DWELL from any state, load mode<=manual_on, clear the filter (candidate 0, count 0, manual target 0) and restart the dwell count.
REQ-024 Watchdog counter SHALL clear on cmd_valid and increment otherwise, saturating; it is active only when mode=1.
REQ-025 On reaching TIMEOUT_CYCLES in RUN or DWELL with mode=1, the arbiter SHALL enter TIMEOUT and clear the manual target.
REQ-026 TIMEOUT->IDLE SHALL occur on cmd_valid; a mode change SHALL take priority per REQ-023.
REQ-027 Simultaneous events SHALL resolve by priority: mode change > watchdog expiry > reversal > normal RUN update.
REQ-028 A target change during DWELL SHALL NOT restart the dwell; the latest target is applied on exit.
REQ-029 drive_cmd, mode, timeout and fsm_state SHALL all be registered, with no combinational path from input to output.

Reset
REQ-030 While reset=1, regardless of clk: state=IDLE, drive_cmd=0, mode=0, timeout=0, fsm_state=0, all counters 0, and filter candidate/target=0.
REQ-031 Reset asserted mid-DWELL or mid-TIMEOUT SHALL abort immediately, and the first post-reset cycle follows REQ-020.

Verification
REQ-032 mode=1; two cmd_valid pulses with 0x01 -> drive_cmd=0x1 one cycle after the second pulse; a single pulse with 0x01 leaves drive_cmd unchanged.
REQ-033 RUN with drive_cmd=0x1; two pulses with 0x04 -> drive_cmd=0x0 and fsm_state=2 for DWELL_CYCLES cycles, then drive_cmd=0x4.
REQ-034 Bytes 0x0A and 0x0A -> drive_cmd=0x1; bytes 0x07 and 0x07 -> drive_cmd=0x0.
REQ-035 mode=1, no cmd_valid for TIMEOUT_CYCLES (reduced to 20) -> timeout=1, fsm_state=3, drive_cmd=0; a cmd_valid pulse then gives fsm_state=0, then 1.
REQ-036 manual_on toggled 1->0 with auto_command=0x9 -> DWELL, then drive_cmd=0x9 and mode=0; reset pulsed mid-DWELL -> all outputs 0 immediately.
